// File: rtl/rhd_spi_if.sv
// SPI pin bundle between an RHD-style SPI master and the chip (or its emulator).
interface rhd_spi_if;
    logic SCLK;
    logic CS;
    logic MOSI;
    logic MISO;

    modport master (output SCLK, output CS, output MOSI, input MISO);
    modport slave  (input SCLK, input CS, input MOSI, output MISO);
endinterface

// File: rtl/rhd_spi_slave_emulator.sv
// RHD2000-style SPI responder: oversampled pins, 32-bit frames, results returned two frames later.
module rhd_spi_slave_emulator #(
    parameter int unsigned NUM_RW  = 40,
    parameter logic [7:0]  CHIP_ID = 8'h01
) (
    input  logic        clk,
    input  logic        rstn,
    rhd_spi_if.slave    spi,
    input  logic [15:0] sample_in,
    output logic        conv_valid,
    output logic [5:0]  conv_chan,
    output logic        cal_pulse,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] cmd_out
);

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned ADDR_W     = 6;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

    state_t                  state;
    logic [2:0]              sclk_sync;
    logic [2:0]              cs_sync;
    logic [1:0]              mosi_sync;
    logic [FRAME_BITS-1:0]   rx;
    logic [FRAME_BITS-1:0]   tx;
    logic [FRAME_BITS-1:0]   pipe_a;
    logic [FRAME_BITS-1:0]   pipe_b;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    cs_pend;
    logic                    miso;
    logic [7:0]              regs [NUM_RW];

    logic                    sclk_rise;
    logic                    sclk_fall;
    logic                    cs_rise;
    logic                    cs_fall;
    logic [15:0]             cmd;
    logic [ADDR_W-1:0]       addr;
    logic [7:0]              data;
    logic [FRAME_BITS-1:0]   result;
    logic                    is_conv;
    logic                    is_cal;
    logic                    do_write;

    assign spi.MISO = miso;

    // Edges come from the 2nd/3rd synchronizer stages, so MOSI is taken from its 2nd stage too.
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];

    // Command decode and result for the frame held in rx.
    always_comb begin
        cmd      = rx[31:16];
        addr     = cmd[13:8];
        data     = cmd[7:0];
        result   = '0;
        is_conv  = 1'b0;
        is_cal   = 1'b0;
        do_write = 1'b0;
        case (cmd[15:14])
            2'b00: begin
                is_conv = 1'b1;
                result  = {16'h0, sample_in};
            end
            2'b01: is_cal = (cmd[15:8] == 8'h55);
            2'b10: begin
                do_write = (32'(addr) < NUM_RW);
                result   = {16'h0, 8'hFF, data};
            end
            default: begin
                if (32'(addr) < NUM_RW) begin
                    result = {24'h0, regs[addr]};
                end else if (addr == 6'd63) begin
                    result = {24'h0, CHIP_ID};
                end
            end
        endcase
    end

    // CS synchronizer resets low so a frame only starts on a real CS falling edge after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            sclk_sync  <= '0;
            cs_sync    <= '0;
            mosi_sync  <= '0;
            rx         <= '0;
            tx         <= '0;
            pipe_a     <= '0;
            pipe_b     <= '0;
            bit_cnt    <= '0;
            cs_pend    <= 1'b0;
            miso       <= 1'b0;
            conv_valid <= 1'b0;
            conv_chan  <= '0;
            cal_pulse  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            cmd_out    <= '0;
            for (int i = 0; i < int'(NUM_RW); i++) begin
                regs[i] <= '0;
            end
        end else begin
            sclk_sync  <= {sclk_sync[1:0], spi.SCLK};
            cs_sync    <= {cs_sync[1:0], spi.CS};
            mosi_sync  <= {mosi_sync[0], spi.MOSI};
            conv_valid <= 1'b0;
            cal_pulse  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (cs_fall || cs_pend) begin
                        cs_pend <= 1'b0;
                        tx      <= pipe_b;
                        miso    <= pipe_b[31];
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        miso <= 1'b0;
                        if (bit_cnt == CNT_FULL) begin
                            state <= DECODE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (sclk_rise) begin
                        rx <= {rx[30:0], mosi_sync[1]};
                        if (bit_cnt != CNT_SAT) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (sclk_fall && (bit_cnt != '0)) begin
                        tx   <= {tx[30:0], 1'b0};
                        miso <= tx[30];
                    end
                end
                DECODE: begin
                    miso       <= 1'b0;
                    cs_pend    <= cs_fall;
                    pipe_b     <= pipe_a;
                    pipe_a     <= result;
                    cmd_out    <= cmd;
                    frame_done <= 1'b1;
                    if (is_conv) begin
                        conv_valid <= 1'b1;
                        conv_chan  <= addr;
                    end
                    if (is_cal) begin
                        cal_pulse <= 1'b1;
                    end
                    if (do_write) begin
                        regs[addr] <= data;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rhd_spi_slave_emulator.sv
// Scoreboard bench for the RHD SPI responder: expected MISO words are queued, a monitor compares.
module tb_rhd_spi_slave_emulator;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] sample_in;
    logic        conv_valid;
    logic [5:0]  conv_chan;
    logic        cal_pulse;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] cmd_out;

    rhd_spi_if spi();

    rhd_spi_slave_emulator #(.NUM_RW(40), .CHIP_ID(8'h01)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .spi        (spi),
        .sample_in  (sample_in),
        .conv_valid (conv_valid),
        .conv_chan  (conv_chan),
        .cal_pulse  (cal_pulse),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .cmd_out    (cmd_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err  = 0;
    int n_cal  = 0;
    int n_conv = 0;
    int frame_idx = 0;

    logic [31:0] exp_miso_q[$];
    logic [31:0] got_miso_q[$];
    logic [5:0]  exp_chan_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: compares captured MISO words and DUT pulses against the queued expectations.
    always @(negedge clk) begin
        if (got_miso_q.size() > 0) begin
            frame_idx++;
            if (exp_miso_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL miso_extra frame %0d: got %h expected nothing", frame_idx, got_miso_q.pop_front());
            end else begin
                check($sformatf("miso_frame%0d", frame_idx), got_miso_q.pop_front(), exp_miso_q.pop_front());
            end
        end
        if (frame_done) n_done++;
        if (frame_err)  n_err++;
        if (cal_pulse)  n_cal++;
        if (conv_valid) begin
            n_conv++;
            if (exp_chan_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL conv_unexpected: got chan %0d expected no conv_valid", conv_chan);
            end else begin
                check("conv_chan", 32'(conv_chan), 32'(exp_chan_q.pop_front()));
            end
        end
    end

    // Clocks n bits of word out on MOSI, sampling MISO at each SCLK rise like the master would.
    task automatic clock_bits(input logic [31:0] word, input int nbits, output logic [31:0] rxw);
        rxw = '0;
        for (int i = 0; i < nbits; i++) begin
            spi.MOSI = word[31-i];
            repeat (4) @(negedge clk);
            spi.SCLK = 1'b1;
            rxw[31-i] = spi.MISO;
            repeat (8) @(negedge clk);
            spi.SCLK = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send(input logic [31:0] word, input int nbits, input logic [31:0] exp);
        logic [31:0] rxw;
        if (nbits == 32) exp_miso_q.push_back(exp);
        spi.CS = 1'b0;
        repeat (8) @(negedge clk);
        clock_bits(word, nbits, rxw);
        repeat (4) @(negedge clk);
        spi.CS = 1'b1;
        repeat (10) @(negedge clk);
        if (nbits == 32) got_miso_q.push_back(rxw);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_before;
        logic [31:0] partial;
        rstn      = 1'b0;
        spi.SCLK  = 1'b0;
        spi.CS    = 1'b1;
        spi.MOSI  = 1'b0;
        sample_in = 16'h0;
        repeat (3) @(negedge clk);
        check("reset_miso",       32'(spi.MISO),   32'h0);
        check("reset_conv_valid", 32'(conv_valid), 32'h0);
        check("reset_conv_chan",  32'(conv_chan),  32'h0);
        check("reset_cmd_out",    32'(cmd_out),    32'h0);
        check("reset_frame_done", 32'(frame_done), 32'h0);
        check("reset_frame_err",  32'(frame_err),  32'h0);
        rstn = 1'b1;
        repeat (6) @(negedge clk);

        // Write/read pipeline
        send(32'h8512_0000, 32, 32'h0000_0000);
        send(32'hC500_0000, 32, 32'h0000_0000);
        send(32'hC500_0000, 32, 32'h0000_FF12);
        check("frame_done_after_3", 32'(n_done), 32'd3);

        // CONVERT channel 7, then two dummy frames
        sample_in = 16'hBEEF;
        exp_chan_q.push_back(6'd7);
        send(32'h0700_0000, 32, 32'h0000_0012);
        sample_in = 16'h0;
        send(32'hC500_0000, 32, 32'h0000_0012);
        send(32'hFF00_0000, 32, 32'h0000_BEEF);
        check("conv_count", 32'(n_conv), 32'd1);

        // Out-of-range write then read, chip ID result returned meanwhile
        send(32'hA833_0000, 32, 32'h0000_0012);
        send(32'hE800_0000, 32, 32'h0000_0001);
        send(32'h5500_0000, 32, 32'h0000_FF33);
        check("cal_count", 32'(n_cal), 32'd1);

        // CONVERT channel 63, then an aborted WRITE to reg7
        sample_in = 16'h1234;
        exp_chan_q.push_back(6'd63);
        send(32'h3F00_0000, 32, 32'h0000_0000);
        sample_in = 16'h0;
        done_before = n_done;
        send(32'h8777_0000, 20, 32'h0);
        check("abort_frame_err",  32'(n_err),  32'd1);
        check("abort_no_done",    32'(n_done), 32'(done_before));
        send(32'hC700_0000, 32, 32'h0000_0000);
        send(32'h6A00_0000, 32, 32'h0000_1234);
        check("cmd_out_clear", 32'(cmd_out), 32'h0000_6A00);
        send(32'hC500_0000, 32, 32'h0000_0000);
        send(32'h6A00_0000, 32, 32'h0000_0000);

        // Reset in the middle of a frame
        spi.CS = 1'b0;
        repeat (8) @(negedge clk);
        clock_bits(32'h8599_0000, 10, partial);
        rstn = 1'b0;
        #1;
        check("midreset_miso",    32'(spi.MISO), 32'h0);
        check("midreset_cmd_out", 32'(cmd_out),  32'h0);
        @(negedge clk);
        spi.CS = 1'b1;
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        send(32'hC500_0000, 32, 32'h0000_0000);
        send(32'hC500_0000, 32, 32'h0000_0000);
        send(32'h6A00_0000, 32, 32'h0000_0000);

        repeat (20) @(negedge clk);
        check("miso_queue_drained", 32'(exp_miso_q.size()), 32'd0);
        check("chan_queue_drained", 32'(exp_chan_q.size()), 32'd0);
        check("total_frame_done",   32'(n_done), 32'd17);
        check("total_frame_err",    32'(n_err),  32'd1);
        check("total_conv",         32'(n_conv), 32'd2);
        check("total_cal",          32'(n_cal),  32'd1);
        check("final_cmd_out",      32'(cmd_out), 32'h0000_6A00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rhd_spi_slave_emulator.md
Name: rhd_spi_slave_emulator

Overview:
- Emulates the SPI responder side of an RHD2000-family amplifier chip for hardware-in-loop checks of the SPI master.
- Oversamples SCLK, CS and MOSI on the system clock.
- Decodes 32-bit frames carrying RHD commands in bits [31:16], and returns each command's result two frames later on MISO, as the real chip does.
- Sits on the board-side SPI pins in place of the chip; the user logic supplies sample values.

Parameters:
- NUM_RW, 40: number of writable 8-bit registers (addresses 0..NUM_RW-1).
- CHIP_ID, 8'h01: value returned by a READ of address 63.

Ports:
- clk  input  1  system clock; SCLK is at most clk/8.
- rstn  input  1  reset; asynchronous, active-low.
- SCLK  input  1  SPI clock from the master; idles low.
- CS  input  1  chip select, active-low.
- MOSI  input  1  serial command, MSB first.
- MISO  output  1  serial response, MSB first.
- sample_in  input  16  sample value for the current CONVERT; captured on the conv_valid cycle.
- conv_valid  output  1  one-cycle pulse when a CONVERT is decoded.
- conv_chan  output  6  channel of the last CONVERT.
- cal_pulse  output  1  one-cycle pulse on CALIBRATE.
- frame_done  output  1  one-cycle pulse when a valid 32-bit frame is decoded.
- frame_err  output  1  one-cycle pulse when a frame is aborted.
- cmd_out  output  16  command field of the last valid frame.

Behaviour:
- Reset:
  - All outputs are 0; conv_chan and cmd_out are 0.
  - Register file is cleared, the bit counter is 0, and both response pipeline stages are 32'h0.
  - Reset mid-frame discards the frame; the next frame starts only after a CS falling edge.
- Input conditioning:
  - SCLK, CS and MOSI each pass through 2-flop synchronizers.
  - Edges are detected from the 2nd and 3rd stages.
  - All edge-driven actions occur 3 clk after the pin edge.
- States:
  - IDLE: CS high; MISO=0.
    - CS fall → SHIFT. Load the shift register from pipe_b, drive MISO=pipe_b[31], clear the bit counter.
  - SHIFT:
    - SCLK rise: capture MOSI into rx[0] with rx shifted left; bit counter +1, saturating at 33.
    - SCLK fall: shift tx left and drive MISO = new tx[31].
    - A SCLK fall before any rise is ignored; the first bit is already presented.
    - CS rise → DECODE if bit count == 32; otherwise pulse frame_err, leave the pipeline unchanged, → IDLE.
    - Simultaneous CS rise and SCLK edge: the CS rise wins and the edge is ignored.
  - DECODE (1 cycle): cmd = rx[31:16]; rx[15:0] is ignored.
    - Compute result, then pipe_b <= pipe_a and pipe_a <= result.
    - Update cmd_out, pulse frame_done → IDLE.
    - A CS fall during DECODE is not lost: it is handled on the next cycle from IDLE.
- Command decode and result:
  - cmd[15:14]=00 CONVERT, channel cmd[13:8]:
    - Pulse conv_valid and set conv_chan.
    - Result {16'h0, sample_in}.
  - cmd[15:8]=8'h55 CALIBRATE: pulse cal_pulse; result 32'h0.
  - cmd[15:8]=8'h6A CLEAR: result 32'h0.
  - Other cmd[15:14]=01 values: result 32'h0.
  - cmd[15:14]=10 WRITE, addr cmd[13:8], data cmd[7:0]:
    - Store if addr < NUM_RW; otherwise ignore the write.
    - Result {16'h0, 8'hFF, data}, returned whether or not stored.
  - cmd[15:14]=11 READ, addr a:
    - Result {24'h0, reg[a]} for a < NUM_RW.
    - Result {24'h0, CHIP_ID} for a == 63.
    - Result 32'h0 otherwise.
    - A READ sees the effect of every earlier frame's WRITE.
- Pipeline latency: frame N transmits the result of frame N-2. Aborted frames do not advance the pipeline.
- MISO is a plain output and is 0 whenever CS is high (IDLE, DECODE).

Test Plan:
- Reset, then three valid frames: WRITE 0x8512 (reg5=0x12), READ 0xC500, READ 0xC500.
  - Frame 3 MISO = 32'h0000FF12.
  - Frame 4 (any command) MISO = 32'h00000012.
  - frame_done pulses 3 times in frames 1–3.
- CONVERT ch 7 (0x0700) with sample_in=16'hBEEF, followed by two dummy frames:
  - conv_valid pulses once with conv_chan=7.
  - The 2nd later frame returns 32'h0000BEEF.
- READ 0xFF00 → result 32'h00000001 two frames later.
- WRITE 0xA833 (addr 40 ≥ NUM_RW) followed by READ 0xE800:
  - The WRITE returns 32'h0000FF33.
  - The READ returns 32'h0.
- Abort: CS raised after 20 SCLK rises.
  - frame_err pulses and frame_done does not.
  - The next valid frame's MISO equals the value expected as if the aborted frame never occurred.
- rstn asserted mid-frame after 10 bits:
  - MISO=0 immediately.
  - After release, the next frame returns 32'h0 and the register file reads 0.
